// File: rtl/dmem_lsu_if.sv
// Request/response channel between the MEM-stage LSU address path and the data memory.
// The master drives requests; the slave (dmem_lsu) answers with a one-cycle response strobe.
interface dmem_lsu_if #(
    parameter int DMEM_W = 11
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [DMEM_W-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_split_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_split_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_split_o
    );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed data RAM with load/store front end: sized, extended accesses,
// misaligned accesses split over two consecutive word accesses.
module dmem_lsu #(
    parameter int DMEM_W    = 11,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    dmem_lsu_if.slave  bus
);
    localparam int IW    = DMEM_W - 2;
    localparam int DEPTH = 1 << IW;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SPLIT} state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_rsp_valid;
    logic          r_rsp_split;
    logic [IW-1:0] r_clr_idx;
    logic          r_we;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_split;
    logic [IW-1:0] r_idx2;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wd_hi;
    logic [31:0]   r_lo;

    logic [IW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_misal;
    logic          w_acc;
    logic [3:0]    w_base_be;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64;
    logic [IW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic [3:0]    w_ram_be;
    logic [31:0]   w_ram_wd;
    logic [31:0]   w_q;
    logic [63:0]   w_dw;
    logic [31:0]   w_sh;
    logic [31:0]   w_ext;

    assign w_idx   = bus.req_addr_i[DMEM_W-1:2];
    assign w_off   = bus.req_addr_i[1:0];
    assign w_acc   = bus.req_valid_i & r_ready;
    assign w_misal = ((bus.req_size_i == 2'b01) && (w_off == 2'b11)) ||
                     (bus.req_size_i[1] && (w_off != 2'b00));

    always_comb begin
        case (bus.req_size_i)
            2'b00:   w_base_be = 4'b0001;
            2'b01:   w_base_be = 4'b0011;
            default: w_base_be = 4'b1111;
        endcase
    end

    // Lanes shifted across a 64-bit window: low half hits word w, high half word w+1.
    assign w_be8  = {4'b0000, w_base_be} << w_off;
    assign w_wd64 = {32'h0, bus.req_wdata_i} << {w_off, 3'b000};

    always_comb begin
        w_ram_idx = w_idx;
        w_ram_we  = 1'b0;
        w_ram_be  = w_be8[3:0];
        w_ram_wd  = w_wd64[31:0];
        case (r_state)
            S_CLEAR: begin
                w_ram_idx = r_clr_idx;
                w_ram_we  = 1'b1;
                w_ram_be  = 4'hF;
                w_ram_wd  = 32'h0;
            end
            S_SPLIT: begin
                w_ram_idx = r_idx2;
                w_ram_we  = r_we;
                w_ram_be  = r_be_hi;
                w_ram_wd  = r_wd_hi;
            end
            default: w_ram_we = w_acc & bus.req_we_i;
        endcase
    end

    // One independent byte-wide RAM per lane, each with its own registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;
            always_ff @(posedge clk_i) begin
                if (w_ram_we && w_ram_be[gi]) begin
                    r_mem[w_ram_idx] <= w_ram_wd[8*gi +: 8];
                end
                r_q <= r_mem[w_ram_idx];
            end
            assign w_q[8*gi +: 8] = r_q;
        end
    endgenerate

    // The previous read word becomes the low half of a split load.
    always_ff @(posedge clk_i) begin
        r_lo <= w_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT_ZERO ? S_CLEAR : S_IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_split <= 1'b0;
            r_clr_idx   <= '0;
            r_we        <= 1'b0;
            r_off       <= 2'b00;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_split     <= 1'b0;
            r_idx2      <= '0;
            r_be_hi     <= 4'h0;
            r_wd_hi     <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_split <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (&r_clr_idx) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_we    <= bus.req_we_i;
                        r_off   <= w_off;
                        r_size  <= bus.req_size_i;
                        r_uns   <= bus.req_unsigned_i;
                        r_split <= w_misal;
                        r_idx2  <= w_idx + 1'b1;
                        r_be_hi <= w_be8[7:4];
                        r_wd_hi <= w_wd64[63:32];
                        if (w_misal) begin
                            r_state <= S_SPLIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                S_SPLIT: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_split <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign w_dw = r_split ? {w_q, r_lo} : {32'h0, w_q};
    assign w_sh = 32'(w_dw >> {r_off, 3'b000});

    always_comb begin
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    assign bus.req_ready_o = r_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_split_o = r_rsp_split;
    assign bus.rsp_rdata_o = (r_rsp_valid && !r_we) ? w_ext : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboarded bench for dmem_lsu: directed loads/stores, split accesses,
// reset abort, and a second instance exercising the post-reset clear sweep.
module tb_dmem_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_nz;

    dmem_lsu_if #(.DMEM_W(11)) bus ();
    dmem_lsu_if #(.DMEM_W(11)) bus_z ();

    dmem_lsu #(.DMEM_W(11), .INIT_ZERO(1'b0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    dmem_lsu #(.DMEM_W(11), .INIT_ZERO(1'b1)) dut_z (
        .clk_i  (clk),
        .rst_ni (rst_nz),
        .bus    (bus_z)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        split;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid_o === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_rsp: got rsp_valid_o=1 at cyc %0d expected no response", cyc);
            end else begin
                e = q.pop_front();
                $display("rsp  cyc=%0d rdata=0x%08h split=%0b", cyc, bus.rsp_rdata_o, bus.rsp_split_o);
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_rdata", bus.rsp_rdata_o, e.data);
                chk("rsp_split", {31'h0, bus.rsp_split_o}, {31'h0, e.split});
            end
        end
    end

    task automatic send(input bit we, input logic [10:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, input logic [31:0] exp,
                        input bit split, input bit push, output int waits);
        exp_t e;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wd;
        waits = 0;
        while (bus.req_ready_o !== 1'b1 && waits < 2000) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (bus.req_ready_o !== 1'b1) begin
            n_checks++;
            n_errs++;
            $display("FAIL accept_timeout: got req_ready_o=%b expected 1", bus.req_ready_o);
        end
        @(posedge clk);
        #1;
        $display("req  cyc=%0d we=%0b addr=0x%03h size=%0d uns=%0b wdata=0x%08h", cyc, we, addr, size, uns, wd);
        if (push) begin
            e.cyc   = cyc + (split ? 1 : 0);
            e.data  = we ? 32'h0 : exp;
            e.split = split;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bus.req_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic zwait_ready(input string name);
        int n = 0;
        while (bus_z.req_ready_o !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 512);
    endtask

    task automatic zreq(input bit we, input logic [10:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input string name);
        bus_z.req_valid_i    = 1'b1;
        bus_z.req_we_i       = we;
        bus_z.req_addr_i     = addr;
        bus_z.req_size_i     = 2'b10;
        bus_z.req_unsigned_i = 1'b0;
        bus_z.req_wdata_i    = wd;
        @(posedge clk);
        #1;
        bus_z.req_valid_i = 1'b0;
        $display("zreq cyc=%0d we=%0b addr=0x%03h rdata=0x%08h", cyc, we, addr, bus_z.rsp_rdata_o);
        chk({name, "_valid"}, {31'h0, bus_z.rsp_valid_o}, 32'h1);
        chk(name, bus_z.rsp_rdata_o, exp);
    endtask

    initial begin
        int w;
        int n;
        rst_n = 1'b0;
        rst_nz = 1'b0;
        bus.req_valid_i = 1'b0;    bus.req_we_i = 1'b0;     bus.req_addr_i = '0;
        bus.req_size_i = 2'b00;    bus.req_unsigned_i = 1'b0; bus.req_wdata_i = '0;
        bus_z.req_valid_i = 1'b0;  bus_z.req_we_i = 1'b0;   bus_z.req_addr_i = '0;
        bus_z.req_size_i = 2'b00;  bus_z.req_unsigned_i = 1'b0; bus_z.req_wdata_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready_o}, 32'h0);
        chk("rst_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_split", {31'h0, bus.rsp_split_o}, 32'h0);
        rst_n = 1'b1;

        // Sign/zero extension
        send(1, 11'h010, 2'b10, 0, 32'h8081_7F80, 32'h0, 0, 1, w);
        idle(1);
        send(0, 11'h010, 2'b00, 0, 32'h0, 32'hFFFF_FF80, 0, 1, w);
        send(0, 11'h010, 2'b00, 1, 32'h0, 32'h0000_0080, 0, 1, w);
        send(0, 11'h012, 2'b01, 0, 32'h0, 32'hFFFF_8081, 0, 1, w);
        send(0, 11'h011, 2'b01, 1, 32'h0, 32'h0000_817F, 0, 1, w);
        idle(1);

        // Misaligned word load
        send(1, 11'h020, 2'b10, 0, 32'h4433_2211, 32'h0, 0, 1, w);
        send(1, 11'h024, 2'b10, 0, 32'h8877_6655, 32'h0, 0, 1, w);
        send(0, 11'h022, 2'b10, 0, 32'h0, 32'h6655_4433, 1, 1, w);
        chk("split_ready_low", {31'h0, bus.req_ready_o}, 32'h0);
        idle(1);
        chk("split_ready_back", {31'h0, bus.req_ready_o}, 32'h1);
        idle(1);

        // Misaligned store wrapping past the top word
        send(1, 11'h7FC, 2'b10, 0, 32'h1234_5678, 32'h0, 0, 1, w);
        send(1, 11'h000, 2'b10, 0, 32'h9ABC_DEF0, 32'h0, 0, 1, w);
        send(1, 11'h7FE, 2'b10, 0, 32'hDDCC_BBAA, 32'h0, 1, 1, w);
        send(0, 11'h7FC, 2'b10, 0, 32'h0, 32'hBBAA_5678, 0, 1, w);
        send(0, 11'h000, 2'b10, 0, 32'h0, 32'h9ABC_DDCC, 0, 1, w);
        idle(2);

        // Back-to-back stream
        send(1, 11'h040, 2'b10, 0, 32'h1122_3344, 32'h0, 0, 1, w);
        chk("b2b_wait0", w, 0);
        send(0, 11'h040, 2'b10, 0, 32'h0, 32'h1122_3344, 0, 1, w);
        chk("b2b_wait1", w, 0);
        send(1, 11'h041, 2'b00, 0, 32'h0000_005A, 32'h0, 0, 1, w);
        chk("b2b_wait2", w, 0);
        send(0, 11'h040, 2'b10, 0, 32'h0, 32'h1122_5A44, 0, 1, w);
        chk("b2b_wait3", w, 0);
        idle(3);

        // Reset during the split of a misaligned store
        send(1, 11'h0F0, 2'b10, 0, 32'h1111_1111, 32'h0, 0, 1, w);
        send(1, 11'h0F4, 2'b10, 0, 32'h2222_2222, 32'h0, 0, 1, w);
        idle(3);
        send(1, 11'h0F3, 2'b01, 0, 32'h0000_BEEF, 32'h0, 1, 0, w);
        rst_n = 1'b0;
        bus.req_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_ready", {31'h0, bus.req_ready_o}, 32'h0);
            chk("mid_rst_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
            chk("mid_rst_rdata", bus.rsp_rdata_o, 32'h0);
            chk("mid_rst_split", {31'h0, bus.rsp_split_o}, 32'h0);
        end
        rst_n = 1'b1;
        send(0, 11'h0F0, 2'b10, 0, 32'h0, 32'hEF11_1111, 0, 1, w);
        send(0, 11'h0F4, 2'b10, 0, 32'h0, 32'h2222_2222, 0, 1, w);
        idle(1);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", q.size(), 32'h0);

        // Clear sweep on the INIT_ZERO instance
        @(negedge clk);
        rst_nz = 1'b1;
        zwait_ready("clear_len_first");
        zreq(1, 11'h1A4, 32'hCAFE_F00D, 32'h0, "z_store");
        zreq(0, 11'h1A4, 32'h0, 32'hCAFE_F00D, "z_load_before");
        rst_nz = 1'b0;
        @(negedge clk);
        chk("z_rst_ready", {31'h0, bus_z.req_ready_o}, 32'h0);
        rst_nz = 1'b1;
        zwait_ready("clear_len_second");
        zreq(0, 11'h1A4, 32'h0, 32'h0, "z_load_cleared");
        zreq(0, 11'h7FC, 32'h0, 32'h0, "z_load_top");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised successor to the core's single-cycle word data memory. Byte-addressed data RAM with an integrated load/store front end:
- synchronous read;
- byte/half/word sizes with sign or zero extension;
- misaligned accesses split into two word accesses by a small FSM;
- valid/ready request channel and a response strobe.

Sits in the MEM stage between the LSU address path and writeback.

Parameters:
- DMEM_W, 11, byte-address width. Depth is 2**(DMEM_W-2) 32-bit words (2 KB default).
- INIT_ZERO, 0, when 1 the RAM is cleared by a sweep after reset (see Behaviour).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request accepted when req_valid_i & req_ready_o at a rising edge.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  DMEM_W  byte address.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  one-cycle response strobe. No back-pressure.
- rsp_rdata_o  output  32  load result. 0 for stores.
- rsp_split_o  output  1  qualifies rsp_valid_o; the access was misaligned and took two word accesses.

Behaviour:
- **Clock/reset:** one clock domain. rst_ni is asynchronous assert, synchronous deassert (external synchroniser).
- **Reset values:** req_ready_o=0 during reset, rsp_valid_o=0, rsp_rdata_o=0, rsp_split_o=0, FSM=IDLE (or CLEAR when INIT_ZERO=1). RAM contents are not reset except via CLEAR.
- **FSM states:** CLEAR, IDLE, SPLIT.
  - CLEAR: writes 0 to one word per cycle, index 0 upward. After the last word, goes to IDLE. req_ready_o=0 throughout.
  - IDLE: req_ready_o=1.
  - SPLIT: req_ready_o=0.
- **Word index and offset:** w=addr[DMEM_W-1:2], off=addr[1:0]. The second word is w+1 modulo depth; it wraps to word 0 at the top.
- **Misaligned:** size half with off=3, or size word with off!=0. Everything else is aligned.
- **Aligned load:**
  - Accepted at edge N. RAM word w is read into a register at N.
  - rsp_valid_o=1 during cycle N+1 with the extracted, extended data.
  - The next request may be accepted at N+1 (back-to-back, throughput 1/cycle).
- **Misaligned load:**
  - Accepted at edge N in IDLE. Word w is captured at N; FSM goes to SPLIT.
  - Word w+1 is captured at N+1; FSM returns to IDLE.
  - rsp_valid_o=1 and rsp_split_o=1 during cycle N+2.
  - Bytes are taken little-endian starting at byte off of w, continuing into w+1.
- **Aligned store:**
  - Byte enables are derived from size/off; wdata is shifted left by 8*off.
  - Written at acceptance edge N. rsp_valid_o=1 in N+1, rsp_rdata_o=0.
- **Misaligned store:**
  - Low bytes go to word w at edge N; high bytes go to word w+1 at edge N+1.
  - rsp_valid_o=1, rsp_split_o=1 in N+2.
- **Extension:**
  - byte: bit 7 replicated into [31:8] unless unsigned.
  - half: bit 15 replicated into [31:16] unless unsigned.
  - word: unchanged.
- **Request capture:** request fields are captured on acceptance. Input changes during SPLIT are ignored.
- **Read-after-write:** a load accepted the cycle after a store to the same word returns the new data. No write-first bypass is needed within one edge because only one access occurs per edge.
- **Reset mid-operation:** asserting rst_ni during SPLIT aborts the access.
  - The second half of a store is not written.
  - No response is issued.
  - The first half, already written, remains.
- **Outputs:** rsp_* are registered; there is no combinational path from req_* to rsp_*.
- **Lint:** no latches; the RAM is coded for inference as a byte-enabled synchronous single-port array.

Test Plan:
1. Sign/zero extension:
   - SW 0x8081_7F80 @0x010; wait 1 cycle.
   - LB @0x010 -> 0xFFFF_FF80.
   - LBU @0x010 -> 0x0000_0080.
   - LH @0x012 -> 0xFFFF_8081.
   - LHU @0x011 -> 0x0000_817F.
   - Each response arrives exactly 1 cycle after acceptance.
2. Misaligned word load:
   - Words @0x20=0x4433_2211, @0x24=0x8877_6655.
   - LW @0x22 -> 0x6655_4433 at acceptance+2, rsp_split_o=1.
   - req_ready_o=0 for exactly one cycle.
3. Misaligned store at top of memory (DMEM_W=11):
   - SW 0xDDCC_BBAA @0x7FE.
   - Then LW @0x7FC -> 0xBBAA_xxxx (upper half = AABB bytes, lower bytes unchanged).
   - LW @0x000 -> 0xxxxx_DDCC (wrap-around).
4. Back-to-back pipelining:
   - Stream SW @0x40, LW @0x40, SB 0x5A @0x41, LW @0x40 on consecutive cycles with req_valid_i held.
   - req_ready_o stays 1; four responses in consecutive cycles.
   - Loads return the stored word, then the word with byte1=0x5A.
5. Reset mid-split:
   - SH 0xBEEF @0x0F3; assert rst_ni low during SPLIT.
   - Word @0x0F0 byte3=0xEF; word @0x0F4 byte0 unchanged.
   - rsp_valid_o never pulses; all outputs 0 while reset is held.
6. INIT_ZERO=1:
   - After reset release, req_ready_o stays 0 for 512 cycles.
   - Then LW of any address -> 0x0000_0000.
